// File: rtl/quat_pkg.sv
// Shared types for the quaternion gather datapath: component width, lane count,
// the packed quaternion record and the per-lane bit vector.
package quat_pkg;

    localparam int QUAT_W     = 32;
    localparam int QUAT_LANES = 4;

    typedef struct packed {
        logic [QUAT_W-1:0] w;
        logic [QUAT_W-1:0] x;
        logic [QUAT_W-1:0] y;
        logic [QUAT_W-1:0] z;
    } quat_t;

    typedef logic [QUAT_LANES-1:0] lane_vec_t;

endpackage

// File: rtl/quat_lane_fifo.sv
// Single-lane sample FIFO with a combinational head. A push into a full FIFO is
// accepted only when the same cycle pops; otherwise it is rejected and drop fires.
module quat_lane_fifo
    import quat_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [QUAT_W-1:0] din,
    output logic [QUAT_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [QUAT_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign drop    = push & ~flush & full & ~do_pop;
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
            else if (!do_push && do_pop) count_reg <= count_reg - 1'b1;
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/quaternion_gather.sv
// Aligns four independently-valid float lanes into whole quaternions behind a
// one-stage valid/ready output register. Define QUATERNION_GATHER_STATS_EN for quat_count.
module quaternion_gather
    import quat_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              qi0_valid,
    input  logic              qi1_valid,
    input  logic              qi2_valid,
    input  logic              qi3_valid,
    input  logic [QUAT_W-1:0] qi0,
    input  logic [QUAT_W-1:0] qi1,
    input  logic [QUAT_W-1:0] qi2,
    input  logic [QUAT_W-1:0] qi3,
    output logic              qo_valid,
    input  logic              qo_ready,
    output logic [QUAT_W-1:0] qo0,
    output logic [QUAT_W-1:0] qo1,
    output logic [QUAT_W-1:0] qo2,
    output logic [QUAT_W-1:0] qo3,
    output logic [3:0]        overflow
`ifdef QUATERNION_GATHER_STATS_EN
    ,
    output logic [31:0]       quat_count
`endif
);

    logic [QUAT_W-1:0] lane_din  [QUAT_LANES];
    logic [QUAT_W-1:0] lane_dout [QUAT_LANES];
    lane_vec_t         lane_push;
    lane_vec_t         lane_empty;
    lane_vec_t         lane_full;
    lane_vec_t         lane_drop;
    logic              all_avail;
    logic              load;
    quat_t             qo_reg;
    logic              qo_valid_reg;
    lane_vec_t         overflow_reg;

    assign lane_push   = {qi3_valid, qi2_valid, qi1_valid, qi0_valid};
    assign lane_din[0] = qi0;
    assign lane_din[1] = qi1;
    assign lane_din[2] = qi2;
    assign lane_din[3] = qi3;

    assign all_avail = ~|lane_empty;
    assign load      = all_avail & (~qo_valid_reg | qo_ready) & ~flush;

    generate
        for (genvar gi = 0; gi < QUAT_LANES; gi++) begin : g_lane
            quat_lane_fifo #(.DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .flush (flush),
                .push  (lane_push[gi]),
                .pop   (load),
                .din   (lane_din[gi]),
                .dout  (lane_dout[gi]),
                .empty (lane_empty[gi]),
                .full  (lane_full[gi]),
                .drop  (lane_drop[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qo_reg       <= '0;
            qo_valid_reg <= 1'b0;
            overflow_reg <= '0;
        end else if (flush) begin
            qo_valid_reg <= 1'b0;
            overflow_reg <= '0;
        end else begin
            if (load) begin
                qo_reg.w     <= lane_dout[0];
                qo_reg.x     <= lane_dout[1];
                qo_reg.y     <= lane_dout[2];
                qo_reg.z     <= lane_dout[3];
                qo_valid_reg <= 1'b1;
            end else if (qo_ready) begin
                qo_valid_reg <= 1'b0;
            end
            // A rejected sample leaves that lane permanently one behind until flush.
            overflow_reg <= overflow_reg | (lane_drop & lane_full);
        end
    end

    assign qo_valid = qo_valid_reg;
    assign qo0      = qo_reg.w;
    assign qo1      = qo_reg.x;
    assign qo2      = qo_reg.y;
    assign qo3      = qo_reg.z;
    assign overflow = overflow_reg;

`ifdef QUATERNION_GATHER_STATS_EN
    logic [31:0] quat_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         quat_count_reg <= '0;
        else if (flush)                     quat_count_reg <= '0;
        else if (qo_valid_reg && qo_ready)  quat_count_reg <= quat_count_reg + 32'd1;
    end

    assign quat_count = quat_count_reg;
`endif

endmodule

// File: tb/tb_quaternion_gather.sv
// Directed bench for quaternion_gather: a per-cycle vector table for aligned, skewed
// and streaming traffic, then hand sequences for backpressure, overflow, reset and stats.
module tb_quaternion_gather;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        qi0_valid = 1'b0, qi1_valid = 1'b0, qi2_valid = 1'b0, qi3_valid = 1'b0;
    logic [31:0] qi0 = '0, qi1 = '0, qi2 = '0, qi3 = '0;
    logic        qo_valid;
    logic        qo_ready = 1'b0;
    logic [31:0] qo0, qo1, qo2, qo3;
    logic [3:0]  overflow;
`ifdef QUATERNION_GATHER_STATS_EN
    logic [31:0] quat_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    quaternion_gather #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .qi0_valid (qi0_valid),
        .qi1_valid (qi1_valid),
        .qi2_valid (qi2_valid),
        .qi3_valid (qi3_valid),
        .qi0       (qi0),
        .qi1       (qi1),
        .qi2       (qi2),
        .qi3       (qi3),
        .qo_valid  (qo_valid),
        .qo_ready  (qo_ready),
        .qo0       (qo0),
        .qo1       (qo1),
        .qo2       (qo2),
        .qo3       (qo3),
        .overflow  (overflow)
`ifdef QUATERNION_GATHER_STATS_EN
        ,
        .quat_count(quat_count)
`endif
    );

    typedef struct packed {
        logic [3:0]       v;
        logic [3:0][31:0] d;
        logic             ready;
        logic             exp_valid;
        logic [3:0][31:0] exp_q;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl [NVEC];

    function automatic logic [31:0] mk(input int k, input int n);
        return 32'hA000_0000 | (32'(k) << 8) | 32'(n);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_q(input string name, input int k);
        chk({name, ".valid"}, {31'd0, qo_valid}, 32'd1);
        chk({name, ".w"}, qo0, mk(k, 0));
        chk({name, ".x"}, qo1, mk(k, 1));
        chk({name, ".y"}, qo2, mk(k, 2));
        chk({name, ".z"}, qo3, mk(k, 3));
        $display("beat %s: %08h %08h %08h %08h", name, qo0, qo1, qo2, qo3);
    endtask

    task automatic set_all(input logic en, input int k);
        qi0_valid = en; qi1_valid = en; qi2_valid = en; qi3_valid = en;
        qi0 = mk(k, 0); qi1 = mk(k, 1); qi2 = mk(k, 2); qi3 = mk(k, 3);
    endtask

    initial begin
        for (int i = 0; i < NVEC; i++) begin
            tbl[i] = '0;
            tbl[i].ready = 1'b1;
        end
        // Aligned: all lanes in cycle 5, beat visible in cycle 7.
        tbl[5].v = 4'hF;
        tbl[5].d = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        tbl[7].exp_valid = 1'b1;
        tbl[7].exp_q = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        // Skew: lanes at 13,14,16,19 -> beat at 21.
        tbl[13].v[0] = 1'b1; tbl[13].d[0] = 32'h1111_0000;
        tbl[14].v[1] = 1'b1; tbl[14].d[1] = 32'h2222_0000;
        tbl[16].v[2] = 1'b1; tbl[16].d[2] = 32'h3333_0000;
        tbl[19].v[3] = 1'b1; tbl[19].d[3] = 32'h4444_0000;
        tbl[21].exp_valid = 1'b1;
        tbl[21].exp_q = {32'h4444_0000, 32'h3333_0000, 32'h2222_0000, 32'h1111_0000};
        // Streaming: three back-to-back quaternions, beats on consecutive cycles.
        for (int k = 0; k < 3; k++) begin
            tbl[23+k].v = 4'hF;
            tbl[25+k].exp_valid = 1'b1;
            for (int n = 0; n < 4; n++) begin
                tbl[23+k].d[n]     = mk(k, n);
                tbl[25+k].exp_q[n] = mk(k, n);
            end
        end

        repeat (3) @(negedge clk);
        chk("reset.valid", {31'd0, qo_valid}, 32'd0);
        chk("reset.qo0", qo0, 32'd0);
        chk("reset.qo3", qo3, 32'd0);
        chk("reset.overflow", {28'd0, overflow}, 32'd0);
`ifdef QUATERNION_GATHER_STATS_EN
        chk("reset.quat_count", quat_count, 32'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d.valid", i), {31'd0, qo_valid}, {31'd0, tbl[i].exp_valid});
            chk($sformatf("vec%0d.overflow", i), {28'd0, overflow}, 32'd0);
            if (tbl[i].exp_valid) begin
                chk($sformatf("vec%0d.w", i), qo0, tbl[i].exp_q[0]);
                chk($sformatf("vec%0d.x", i), qo1, tbl[i].exp_q[1]);
                chk($sformatf("vec%0d.y", i), qo2, tbl[i].exp_q[2]);
                chk($sformatf("vec%0d.z", i), qo3, tbl[i].exp_q[3]);
            end
            $display("vec %0d: valid=%0b q=%08h %08h %08h %08h ovf=%04b",
                     i, qo_valid, qo0, qo1, qo2, qo3, overflow);
            qi0_valid = tbl[i].v[0]; qi1_valid = tbl[i].v[1];
            qi2_valid = tbl[i].v[2]; qi3_valid = tbl[i].v[3];
            qi0 = tbl[i].d[0]; qi1 = tbl[i].d[1]; qi2 = tbl[i].d[2]; qi3 = tbl[i].d[3];
            qo_ready = tbl[i].ready;
        end

        // Backpressure: five quaternions fill output register plus all four FIFO slots,
        // then a sixth is pushed into full lanes in the same cycle as the first pop.
        @(negedge clk);
        set_all(1'b0, 0);
        qo_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            set_all(1'b1, 10 + k);
        end
        @(negedge clk);
        set_all(1'b0, 0);
        @(negedge clk);
        chk_q("bp.hold0", 10);
        @(negedge clk);
        chk_q("bp.hold1", 10);
        chk("bp.overflow", {28'd0, overflow}, 32'd0);
        qo_ready = 1'b1;
        set_all(1'b1, 15);
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            set_all(1'b0, 0);
            chk_q($sformatf("bp.beat%0d", j), 10 + j);
        end
        @(negedge clk);
        chk("bp.drained", {31'd0, qo_valid}, 32'd0);
        chk("bp.overflow_end", {28'd0, overflow}, 32'd0);

        // Overflow on lane 2 alone, then flush; samples in the flush cycle are discarded.
        qo_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            qi2_valid = 1'b1;
            qi2 = mk(20 + k, 2);
        end
        @(negedge clk);
        qi2_valid = 1'b0;
        chk("ovf.flag", {28'd0, overflow}, 32'd4);
        chk("ovf.valid", {31'd0, qo_valid}, 32'd0);
        @(negedge clk);
        flush = 1'b1;
        set_all(1'b1, 40);
        @(negedge clk);
        flush = 1'b0;
        chk("flush.overflow", {28'd0, overflow}, 32'd0);
        chk("flush.valid", {31'd0, qo_valid}, 32'd0);
        set_all(1'b1, 30);
        @(negedge clk);
        set_all(1'b0, 0);
        @(negedge clk);
        chk_q("flush.realign", 30);
        qo_ready = 1'b1;
        @(negedge clk);
        chk("flush.consumed", {31'd0, qo_valid}, 32'd0);

        // Reset mid-stream with a held beat and partly filled lanes.
        qo_ready = 1'b0;
        set_all(1'b1, 50);
        @(negedge clk);
        set_all(1'b0, 0);
        qi0_valid = 1'b1; qi1_valid = 1'b1;
        qi0 = mk(51, 0); qi1 = mk(51, 1);
        @(negedge clk);
        set_all(1'b0, 0);
        @(negedge clk);
        chk_q("rst.before", 50);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.valid", {31'd0, qo_valid}, 32'd0);
        chk("rst.qo0", qo0, 32'd0);
        chk("rst.qo1", qo1, 32'd0);
        chk("rst.qo2", qo2, 32'd0);
        chk("rst.qo3", qo3, 32'd0);
        chk("rst.overflow", {28'd0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        qo_ready = 1'b1;
        set_all(1'b1, 60);
        @(negedge clk);
        set_all(1'b0, 0);
        chk("rst.lat1", {31'd0, qo_valid}, 32'd0);
        @(negedge clk);
        chk_q("rst.after", 60);

`ifdef QUATERNION_GATHER_STATS_EN
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("stats.flush0", quat_count, 32'd0);
        for (int k = 0; k < 10; k++) begin
            set_all(1'b1, 70 + k);
            @(negedge clk);
        end
        set_all(1'b0, 0);
        repeat (3) @(negedge clk);
        chk("stats.count10", quat_count, 32'd10);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("stats.flush", quat_count, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
